// File: rtl/counter_pkg.sv
// Shared types and mode constants for the up counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } cnt_state_t;

    localparam int MODE_WRAP    = 0;
    localparam int MODE_ONESHOT = 1;

endpackage

// File: rtl/counter_up_tc.sv
// Up counter 0..LIMIT with terminal count, wrap carry pulse and one-shot done flag.
// Optional synchronous load port set enabled by `COUNTER_UP_LOAD_EN.
module counter_up_tc
    import counter_pkg::*;
#(
    parameter int unsigned dw      = 8,
    parameter int          LIMIT   = 7,
    parameter int          ONESHOT = MODE_WRAP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          ena,
`ifdef COUNTER_UP_LOAD_EN
    input  logic          load,
    input  logic [dw-1:0] load_val,
`endif
    output logic [dw-1:0] result,
    output logic          tc,
    output logic          carry,
    output logic          done,
    output logic          active
);

    localparam logic [dw-1:0] LIM        = dw'(LIMIT);
    localparam bit            IS_ONESHOT = (ONESHOT == MODE_ONESHOT);

    if (LIMIT < 0 || longint'(LIMIT) > ((longint'(1) << dw) - longint'(1))) begin : g_limit_bad
        $error("counter_up_tc: LIMIT does not fit in dw bits");
    end
    if (ONESHOT != MODE_WRAP && ONESHOT != MODE_ONESHOT) begin : g_mode_bad
        $error("counter_up_tc: ONESHOT must be 0 or 1");
    end

    cnt_state_t    state, state_nxt;
    logic [dw-1:0] result_nxt;
    logic          carry_nxt;
    logic          done_nxt;

`ifdef COUNTER_UP_LOAD_EN
    logic [dw-1:0] load_sat;
    assign load_sat = (load_val > LIM) ? LIM : load_val;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            result <= '0;
            carry  <= 1'b0;
            done   <= 1'b0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
            carry  <= carry_nxt;
            done   <= done_nxt;
            active <= (state_nxt == COUNT);
        end
    end

    // Next state / next count: clr > load > ena > hold
    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        carry_nxt  = 1'b0;
        done_nxt   = done;

        if (clr) begin
            state_nxt  = IDLE;
            result_nxt = '0;
            done_nxt   = 1'b0;
`ifdef COUNTER_UP_LOAD_EN
        end else if (load) begin
            result_nxt = load_sat;
            done_nxt   = 1'b0;
            if (load_sat == '0) begin
                state_nxt = IDLE;
            end else if (load_sat == LIM && IS_ONESHOT) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = COUNT;
            end
`endif
        end else if (ena) begin
            unique case (state)
                IDLE: begin
                    if (LIM == '0) begin
                        if (IS_ONESHOT) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            carry_nxt = 1'b1;
                        end
                    end else begin
                        result_nxt = dw'(1);
                        // LIMIT==1 in one-shot mode terminates on the very first count
                        if (IS_ONESHOT && LIM == dw'(1)) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (result < LIM) begin
                        result_nxt = result + dw'(1);
                        if (IS_ONESHOT && (result + dw'(1)) == LIM) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end else if (!IS_ONESHOT) begin
                        result_nxt = '0;
                        carry_nxt  = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                DONE: begin
                    result_nxt = LIM;
                    done_nxt   = 1'b1;
                end
                default: begin
                    state_nxt  = IDLE;
                    result_nxt = '0;
                    done_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign tc = (result == LIM);

endmodule

// File: tb/tb_counter_up_tc.sv
// Directed bench for counter_up_tc: wrap, one-shot, LIMIT==0, two-stage chain and async reset.
// Load behaviour is exercised when `COUNTER_UP_LOAD_EN is defined.
module tb_counter_up_tc;

    localparam int W_RES = 0, W_CAR = 1, W_TC = 2, W_ACT = 3, W_DONE = 4;
    localparam int O_RES = 5, O_DONE = 6, O_ACT = 7, O_TC = 8;
    localparam int C1_RES = 9, C1_CAR = 10, C2_RES = 11, C2_CAR = 12;
    localparam int Z_RES = 13, Z_CAR = 14, Z_TC = 15;

    logic clk = 1'b0;
    logic reset;
    logic clr_w, ena_w, clr_o, ena_o, clr_c, ena_c, clr_z, ena_z;
    logic load_w, load_o;
    logic [7:0] load_val_w, load_val_o;

    logic [7:0] res_w, res_o, res_c1, res_c2, res_z;
    logic tc_w, car_w, done_w, act_w;
    logic tc_o, car_o, done_o, act_o;
    logic tc_c1, car_c1, done_c1, act_c1;
    logic tc_c2, car_c2, done_c2, act_c2;
    logic tc_z, car_z, done_z, act_z;

    always #5 clk = ~clk;

    counter_up_tc #(.dw(8), .LIMIT(7), .ONESHOT(0)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr_w), .ena(ena_w),
`ifdef COUNTER_UP_LOAD_EN
        .load(load_w), .load_val(load_val_w),
`endif
        .result(res_w), .tc(tc_w), .carry(car_w), .done(done_w), .active(act_w)
    );

    counter_up_tc #(.dw(8), .LIMIT(3), .ONESHOT(1)) u_one (
        .clk(clk), .reset(reset), .clr(clr_o), .ena(ena_o),
`ifdef COUNTER_UP_LOAD_EN
        .load(load_o), .load_val(load_val_o),
`endif
        .result(res_o), .tc(tc_o), .carry(car_o), .done(done_o), .active(act_o)
    );

    counter_up_tc #(.dw(8), .LIMIT(9), .ONESHOT(0)) u_c1 (
        .clk(clk), .reset(reset), .clr(clr_c), .ena(ena_c),
`ifdef COUNTER_UP_LOAD_EN
        .load(1'b0), .load_val(8'd0),
`endif
        .result(res_c1), .tc(tc_c1), .carry(car_c1), .done(done_c1), .active(act_c1)
    );

    counter_up_tc #(.dw(8), .LIMIT(5), .ONESHOT(0)) u_c2 (
        .clk(clk), .reset(reset), .clr(clr_c), .ena(car_c1),
`ifdef COUNTER_UP_LOAD_EN
        .load(1'b0), .load_val(8'd0),
`endif
        .result(res_c2), .tc(tc_c2), .carry(car_c2), .done(done_c2), .active(act_c2)
    );

    counter_up_tc #(.dw(8), .LIMIT(0), .ONESHOT(0)) u_zero (
        .clk(clk), .reset(reset), .clr(clr_z), .ena(ena_z),
`ifdef COUNTER_UP_LOAD_EN
        .load(1'b0), .load_val(8'd0),
`endif
        .result(res_z), .tc(tc_z), .carry(car_z), .done(done_z), .active(act_z)
    );

    typedef struct {
        int          id;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] observed(int id);
        case (id)
            W_RES:   return 32'(res_w);
            W_CAR:   return 32'(car_w);
            W_TC:    return 32'(tc_w);
            W_ACT:   return 32'(act_w);
            W_DONE:  return 32'(done_w);
            O_RES:   return 32'(res_o);
            O_DONE:  return 32'(done_o);
            O_ACT:   return 32'(act_o);
            O_TC:    return 32'(tc_o);
            C1_RES:  return 32'(res_c1);
            C1_CAR:  return 32'(car_c1);
            C2_RES:  return 32'(res_c2);
            C2_CAR:  return 32'(car_c2);
            Z_RES:   return 32'(res_z);
            Z_CAR:   return 32'(car_z);
            Z_TC:    return 32'(tc_z);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input int id, input string tag, input logic [31:0] v);
        exp_t e;
        e.id  = id;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Pop every pending expectation and compare against the DUT right now
    task automatic check_now();
        exp_t        e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observed(e.id);
            n_cmp++;
            assert (o === e.val)
            else begin
                n_bad++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        int n;
        reset = 1'b0;
        {clr_w, ena_w, clr_o, ena_o, clr_c, ena_c, clr_z, ena_z} = '0;
        {load_w, load_o} = '0;
        load_val_w = '0;
        load_val_o = '0;

        // Reset state
        @(posedge clk);
        #1;
        expect_v(W_RES, "rst_res", 0);
        expect_v(W_CAR, "rst_car", 0);
        expect_v(W_ACT, "rst_act", 0);
        expect_v(O_DONE, "rst_done", 0);
        check_now();
        reset = 1'b1;

        // Count to 5, then async reset between edges
        ena_w = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            expect_v(W_RES, "pre_rst_res", 32'(k));
            tick();
        end
        #3 reset = 1'b0;
        #1;
        expect_v(W_RES, "async_rst_res", 0);
        expect_v(W_CAR, "async_rst_car", 0);
        expect_v(W_DONE, "async_rst_done", 0);
        expect_v(W_ACT, "async_rst_act", 0);
        check_now();
        ena_w = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Wrap mode: two full laps
        ena_w = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            expect_v(W_RES, "wrap_res", 32'(k % 8));
            expect_v(W_CAR, "wrap_car", 32'(k % 8 == 0));
            expect_v(W_TC, "wrap_tc", 32'(k % 8 == 7));
            expect_v(W_ACT, "wrap_act", 32'(k % 8 != 0));
            tick();
        end

        // clr beats ena at result 4
        for (int k = 1; k <= 4; k++) begin
            expect_v(W_RES, "pre_clr_res", 32'(k));
            tick();
        end
        clr_w = 1'b1;
        expect_v(W_RES, "clr_ena_res", 0);
        expect_v(W_CAR, "clr_ena_car", 0);
        expect_v(W_ACT, "clr_ena_act", 0);
        tick();
        clr_w = 1'b0;
        ena_w = 1'b0;
        expect_v(W_RES, "hold_res", 0);
        tick();

        // One-shot LIMIT=3: stop and hold done, ena ignored until clr
        ena_o = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            n = (k < 3) ? k : 3;
            expect_v(O_RES, "one_res", 32'(n));
            expect_v(O_DONE, "one_done", 32'(k >= 3));
            expect_v(O_ACT, "one_act", 32'(k < 3));
            expect_v(O_TC, "one_tc", 32'(k >= 3));
            tick();
        end
        clr_o = 1'b1;
        expect_v(O_RES, "one_clr_res", 0);
        expect_v(O_DONE, "one_clr_done", 0);
        tick();
        clr_o = 1'b0;
        expect_v(O_RES, "one_restart_res", 1);
        expect_v(O_ACT, "one_restart_act", 1);
        tick();
        ena_o = 1'b0;

        // LIMIT==0 wrap: stays at 0, carry every enabled cycle
        ena_z = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            expect_v(Z_RES, "zero_res", 0);
            expect_v(Z_CAR, "zero_car", 1);
            expect_v(Z_TC, "zero_tc", 1);
            tick();
        end
        ena_z = 1'b0;
        expect_v(Z_CAR, "zero_car_off", 0);
        tick();

        // Two-stage chain: stage 2 steps one cycle after each stage-1 wrap
        ena_c = 1'b1;
        for (int k = 1; k <= 61; k++) begin
            n = (k - 1) / 10;
            expect_v(C1_RES, "chain_s1_res", 32'(k % 10));
            expect_v(C1_CAR, "chain_s1_car", 32'(k % 10 == 0));
            expect_v(C2_RES, "chain_s2_res", 32'(n % 6));
            expect_v(C2_CAR, "chain_s2_car", 32'((k - 1) % 10 == 0 && n > 0 && n % 6 == 0));
            tick();
        end
        ena_c = 1'b0;

`ifdef COUNTER_UP_LOAD_EN
        // Load saturates to LIMIT, then ena wraps with carry
        load_w     = 1'b1;
        load_val_w = 8'd12;
        expect_v(W_RES, "load_sat_res", 7);
        expect_v(W_CAR, "load_sat_car", 0);
        expect_v(W_ACT, "load_sat_act", 1);
        tick();
        load_w = 1'b0;
        ena_w  = 1'b1;
        expect_v(W_RES, "load_wrap_res", 0);
        expect_v(W_CAR, "load_wrap_car", 1);
        tick();
        ena_w = 1'b0;

        load_o     = 1'b1;
        load_val_o = 8'd3;
        expect_v(O_RES, "load_one_res", 3);
        expect_v(O_DONE, "load_one_done", 1);
        expect_v(O_ACT, "load_one_act", 0);
        tick();
        load_o = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
